// File: rtl/mem_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mem_serial_ctrl
//
// Purpose:
//   Sequences the byte-memory -> bit-serial path. A start request captures a
//   first address and a byte count. The controller then fetches each byte from
//   an asynchronous-read memory and shifts it out LSB first, one bit per clock.
//   Status is reported on valid/busy/done.
//
// Optional feature (macro SER_PARITY_EN):
//   When defined, every byte is followed by one extra serial cycle that carries
//   even parity (^byte). A byte then takes 2+DATA_W cycles instead of 1+DATA_W.
//
// Ports:
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high reset; overrides every other input
//   start      in   transfer request, sampled only in IDLE
//   start_addr in   first byte address, captured together with start
//   count      in   number of bytes (0 = none; anything above 2**ADDR_W saturates)
//   mem_data   in   combinational read data for mem_addr
//   mem_addr   out  memory address
//   mem_rd     out  read strobe, high in FETCH
//   ser_out    out  serial data bit (0 whenever ser_valid is low)
//   ser_valid  out  ser_out carries a real bit this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//
// States:
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | present address, load the read data into the shift register
//   SHIFT  | emit one bit per cycle (data bits, then parity if enabled)
//   DONE   | one-cycle completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module mem_serial_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The bit counter has to reach DATA_W when the parity slot is enabled.
  localparam int BIT_W = $clog2(DATA_W + 1);

`ifdef SER_PARITY_EN
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);
`else
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   bytes_left;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [ADDR_W:0]   count_sat;
  logic              last_bit;
  logic              cur_bit;

`ifdef SER_PARITY_EN
  logic              parity_q;
`endif

  // Requests larger than the memory are clipped to one full pass.
  assign count_sat = (count > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH) : count;
  assign last_bit  = (bit_cnt == LAST_BIT);

  // The shift register moves right each SHIFT cycle, so bit 0 is always the
  // current data bit; in the parity slot the stored parity is shown instead.
`ifdef SER_PARITY_EN
  assign cur_bit = (bit_cnt == BIT_W'(DATA_W)) ? parity_q : shift_q[0];
`else
  assign cur_bit = shift_q[0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_next = S_SHIFT;
      S_SHIFT: begin
        if (last_bit) begin
          state_next = (bytes_left != '0) ? S_FETCH : S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address, byte/bit counters, shift register.
  // bytes_left is decremented on each fetch, so at the last bit of a byte it
  // already says whether another byte follows.
  always_ff @(posedge clk) begin
    if (clear) begin
      addr_q     <= '0;
      bytes_left <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_q     <= start_addr;
            bytes_left <= count_sat;
          end
        end
        S_FETCH: begin
          shift_q    <= mem_data;
          bit_cnt    <= '0;
          bytes_left <= bytes_left - 1'b1;
`ifdef SER_PARITY_EN
          parity_q   <= ^mem_data;
`endif
        end
        S_SHIFT: begin
          shift_q <= shift_q >> 1;
          if (last_bit) begin
            bit_cnt <= '0;
            if (bytes_left != '0) begin
              addr_q <= addr_q + 1'b1;   // wraps modulo DEPTH
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are decodes of registered state only; start has no path here.
  assign mem_addr = addr_q;

  always_comb begin
    mem_rd    = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = cur_bit;
        busy      = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
